debug_unit: RTL

- UART-driven run controller for the MIPS_DLX core.
- Pops command bytes from the UART receive FIFO and gates the core's enable: continuous run, single step, or halt.
- After every stop it streams a framed snapshot of the core's debug bus and an enable-cycle counter into the UART transmit FIFO.
- Sits between the uart block's FIFO ports and MIPS_DLX, in the divided clock domain.

---
 rtl/debug_pkg.sv | 14 +
 rtl/debug_frame_tx.sv | 57 +++++
 rtl/debug_unit.sv | 75 +++++++
 3 files changed

// File: rtl/debug_pkg.sv
// debug_pkg: shared constants, command codes and FSM states for the debug unit
package debug_pkg;
    localparam int DEBUG_W = 322;
    localparam int N_BYTES = (DEBUG_W + 7) / 8;
    localparam int FRAME_LEN = N_BYTES + 3;
    localparam int SNAP_W = N_BYTES * 8;
    localparam int IDX_W = $clog2(FRAME_LEN + 1);
    localparam logic [7:0] HEADER = 8'hA5;
    localparam logic [7:0] CMD_RUN = 8'h63;
    localparam logic [7:0] CMD_STEP = 8'h73;
    localparam logic [7:0] CMD_PAUSE = 8'h70;
    localparam logic [7:0] CMD_DUMP = 8'h64;
    typedef enum logic [2:0] {IDLE, DECODE, RUN, STEP, SNAP, SEND} state_t;
endpackage

// File: rtl/debug_frame_tx.sv
// debug_frame_tx: latches a snapshot and count, then streams the dump frame into the TX FIFO
module debug_frame_tx
    import debug_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    input  logic               snap,
    input  logic               active,
    input  logic               tx_full,
    input  logic [DEBUG_W-1:0] debug_signal,
    input  logic [15:0]        count,
    output logic [7:0]         w_data,
    output logic               wr,
    output logic               done
);
    logic [SNAP_W-1:0] snapshot;
    logic [SNAP_W-1:0] shifted;
    logic [15:0]       count_q;
    logic [IDX_W-1:0]  idx;
    logic [IDX_W-1:0]  sel;
    logic [7:0]        cur_byte;

    assign done = idx == IDX_W'(FRAME_LEN);

    // frame byte mux: header, count low/high, then snapshot bytes LSB first
    always_comb begin
        sel = idx - IDX_W'(3);
        shifted = snapshot >> {sel, 3'b000};
        cur_byte = idx == '0 ? HEADER :
                   idx == IDX_W'(1) ? count_q[7:0] :
                   idx == IDX_W'(2) ? count_q[15:8] : shifted[7:0];
    end

    // capture on SNAP; the header goes out during SNAP so the frame starts right after it
    always_ff @(posedge clk) begin
        if (!reset) begin
            snapshot <= '0;
            count_q <= '0;
            idx <= '0;
            wr <= 1'b0;
            w_data <= '0;
        end else begin
            wr <= 1'b0;
            if (snap) begin
                snapshot <= SNAP_W'(debug_signal);
                count_q <= count;
            end
            if (!(snap || active)) begin
                idx <= '0;
            end else if (!tx_full && !done) begin
                wr <= 1'b1;
                w_data <= cur_byte;
                idx <= idx + IDX_W'(1);
            end
        end
    end
endmodule

// File: rtl/debug_unit.sv
// debug_unit: UART command FSM gating the core enable and triggering state dumps
module debug_unit
    import debug_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    input  logic               rx_empty,
    input  logic [7:0]         r_data,
    output logic               rd,
    input  logic               tx_full,
    output logic [7:0]         w_data,
    output logic               wr,
    input  logic [DEBUG_W-1:0] debug_signal,
    input  logic               halt,
    output logic               enable
);
    state_t      state, next;
    logic [7:0]  cmd;
    logic [15:0] count;
    logic        pop;
    logic        done;

    // next state; rd is registered, so a byte whose pop is in flight is not taken again
    always_comb begin
        next = state;
        pop = 1'b0;
        case (state)
            IDLE: begin
                pop = !rx_empty && !rd;
                next = pop ? DECODE : IDLE;
            end
            DECODE: next = (cmd == CMD_RUN || cmd == CMD_STEP) ?
                           (halt ? SNAP : (cmd == CMD_RUN ? RUN : STEP)) :
                           (cmd == CMD_DUMP ? SNAP : IDLE);
            RUN: begin
                pop = !halt && !rx_empty && !rd;
                next = (halt || (pop && r_data == CMD_PAUSE)) ? SNAP : RUN;
            end
            STEP: next = SNAP;
            SNAP: next = SEND;
            SEND: next = done ? IDLE : SEND;
            default: next = IDLE;
        endcase
    end

    // state register plus registered rd, enable, command latch and enable-cycle counter
    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= IDLE;
            rd <= 1'b0;
            enable <= 1'b0;
            cmd <= '0;
            count <= '0;
        end else begin
            state <= next;
            rd <= pop;
            enable <= next == RUN || next == STEP;
            count <= count + 16'(enable);
            if (state == IDLE && pop) cmd <= r_data;
        end
    end

    debug_frame_tx u_frame_tx (
        .clk(clk),
        .reset(reset),
        .snap(state == SNAP),
        .active(state == SEND),
        .tx_full(tx_full),
        .debug_signal(debug_signal),
        .count(count),
        .w_data(w_data),
        .wr(wr),
        .done(done)
    );
endmodule
